instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Parametrised, byte-addressed instruction memory with a streaming word loader and a checked one-cycle read port. It sits between the boot/program loader and the fetch stage of the MIPS core. It holds the program, tracks how much of the memory was actually loaded, and returns full 32-bit instructions. Fetches that are misaligned, out of range or early are flagged instead of returning stale data.

## Interface
- ADDR_BITS, 10, byte-address width of storage; capacity = 2**ADDR_BITS bytes (must be ≥ 2)
- BIG_ENDIAN, 0, 0: byte 0 of a word = bits [7:0]; 1: byte 0 = bits [31:24] (applies to load and read)

- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- load  in  1  load beat strobe; store is written this cycle
- store  in  32  load word
- load_last  in  1  qualifies a load beat as final word of program
- load_full  out  1  write pointer has reached capacity
- load_count  out  ADDR_BITS+1  bytes loaded (program length)
- mem_state  out  2  0 EMPTY, 1 LOADING, 2 RUN
- ready  in  1  fetch request
- address  in  32  fetch byte address
- instruction  out  32  fetched word
- instr_valid  out  1  instruction updated this cycle with valid data
- fault  out  1  request this cycle was rejected

## Operation
- Storage: 2**ADDR_BITS bytes, not reset. Contents survive reset.
- Write pointer wp, ADDR_BITS+1 bits, advances 4 per accepted beat. load_count = wp. load_full = (wp == 2**ADDR_BITS).
- States:
  - EMPTY (reset). A load beat writes bytes 0..3, sets wp=4 and goes to LOADING. If load_last is also set, it goes to RUN instead.
  - LOADING: a load beat with wp < capacity writes bytes wp..wp+3 and sets wp += 4. A beat with load_full=1 is dropped; wp and memory are unchanged. load_last on any beat, dropped or not, goes to RUN.
  - RUN: a load beat restarts the program. It writes bytes 0..3, sets wp=4 and goes to LOADING, or stays in RUN if load_last is set. Old bytes beyond the new length are unreachable.
- load_last without load is ignored.
- Fetch is evaluated only when ready=1. It is accepted iff all of the following hold:
  - mem_state == RUN
  - load=0 in the same cycle (load has priority)
  - address[1:0] == 0
  - address[31:ADDR_BITS] == 0
  - address + 4 ≤ load_count
- Accepted fetch: instruction = bytes address..address+3 in BIG_ENDIAN order; instr_valid=1, fault=0.
- Rejected fetch: instruction holds its value; instr_valid=0, fault=1.
- ready=0: instruction holds; instr_valid=0, fault=0.

## Timing
- Reset (reset_n=0 at a clk edge): mem_state=EMPTY, wp=0, load_full=0, instruction=0, instr_valid=0, fault=0. Reset wins over load and ready in the same cycle.
- Reset mid-load returns to EMPTY with wp=0. Previously written bytes stay but cannot be fetched until reloaded.
- Load latency: the beat is written at edge N. mem_state, load_count and load_full reflect it after edge N. A fetch of that word is accepted no earlier than request cycle N+1.
- Fetch latency: 1 cycle. instruction, instr_valid and fault are registered at the edge that samples ready. A new request is allowed every cycle, giving full throughput.
- Fetch concurrent with the RUN→LOADING restart beat is rejected (load priority).
- wp never wraps; it saturates at capacity.

## Test plan
- Reset, then 3 beats 0x11223344, 0x55667788, 0x99AABBCC with load_last on the third. Expect mem_state=RUN and load_count=12. Fetch 0, 4, 8 on consecutive cycles. Expect those words, each one cycle later, with instr_valid=1.
- BIG_ENDIAN=1: load 0x11223344 as the last beat and fetch 0. Expect instruction=0x11223344. Memory byte 0 must read back as 0x11, checked via hierarchical peek.
- Bounds, after the 12-byte load: fetch 2 → fault=1. Fetch 12 → fault=1. Fetch 0x400 with ADDR_BITS=10 → fault=1. After each, instruction must still hold its prior value.
- Overflow, ADDR_BITS=4: load 5 beats, the last with load_last. Expect load_full=1 after the 4th beat, load_count=16 and the 5th beat dropped. Fetch 12 returns the 4th word.
- Priority and states: fetch while EMPTY → fault=1. With load and ready in the same RUN cycle, expect fault=1, mem_state=LOADING and load_count=4.
- Mid-load reset: drop reset_n after 2 beats. Expect mem_state=EMPTY, load_count=0, instr_valid=0 and fault=0. Fetch 0 → fault=1.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Bundle of load-stream and fetch signals between the program loader / fetch stage (master)
// and the instruction memory (slave).
interface instr_mem_loader_if #(
    parameter int ADDR_BITS = 10
);
    logic                 load;
    logic [31:0]          store;
    logic                 load_last;
    logic                 load_full;
    logic [ADDR_BITS:0]   load_count;
    logic [1:0]           mem_state;
    // Fetch handshake: the master raises ready with address for one cycle per request.
    // One cycle later exactly one of instr_valid (accepted) or fault (rejected) is high.
    // With ready low both stay low, and instruction keeps its last accepted word.
    logic                 ready;
    logic [31:0]          address;
    logic [31:0]          instruction;
    logic                 instr_valid;
    logic                 fault;

    modport master (
        output load, store, load_last, ready, address,
        input  load_full, load_count, mem_state, instruction, instr_valid, fault
    );

    modport slave (
        input  load, store, load_last, ready, address,
        output load_full, load_count, mem_state, instruction, instr_valid, fault
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Byte-addressed instruction memory with a streaming word loader and a checked one-cycle
// fetch port. Only the loaded prefix of the memory is fetchable.
module instr_mem_loader #(
    parameter int ADDR_BITS  = 10,
    parameter int BIG_ENDIAN = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    instr_mem_loader_if.slave  bus
);
    localparam int                 CAP        = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] CAP_W      = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0] WORD_BYTES = (ADDR_BITS + 1)'(4);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t               state;
    logic [ADDR_BITS:0]   wp;
    logic [7:0]           mem [CAP];
    logic [31:0]          instr_q;
    logic                 valid_q;
    logic                 fault_q;

    logic                 full;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_base;
    logic [ADDR_BITS-1:0] rd_base;
    logic [ADDR_BITS:0]   fetch_end;
    logic                 addr_ok;
    logic                 accept;
    logic [31:0]          rd_word;

    function automatic logic [7:0] lane(input logic [31:0] w, input int k);
        return (BIG_ENDIAN != 0) ? w[8*(3-k) +: 8] : w[8*k +: 8];
    endfunction

    assign full      = (wp == CAP_W);
    assign rd_base   = bus.address[ADDR_BITS-1:0];
    // Computed one bit wider than the byte address so a word ending exactly at capacity fits.
    assign fetch_end = {1'b0, rd_base} + WORD_BYTES;
    assign addr_ok   = (bus.address[1:0] == 2'b00) && (bus.address[31:ADDR_BITS] == '0);
    assign accept    = (state == RUN) && !bus.load && addr_ok && (fetch_end <= wp);

    // EMPTY and RUN both (re)start the program at byte 0; LOADING appends until full.
    always_comb begin
        wr_en   = 1'b0;
        wr_base = '0;
        if (reset_n && bus.load) begin
            case (state)
                LOADING: begin
                    wr_en   = !full;
                    wr_base = wp[ADDR_BITS-1:0];
                end
                default: wr_en = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                mem[wr_base + ADDR_BITS'(k)] <= lane(bus.store, k);
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (BIG_ENDIAN != 0) begin
                rd_word[8*(3-k) +: 8] = mem[rd_base + ADDR_BITS'(k)];
            end else begin
                rd_word[8*k +: 8] = mem[rd_base + ADDR_BITS'(k)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= EMPTY;
            wp      <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            valid_q <= bus.ready && accept;
            fault_q <= bus.ready && !accept;
            if (bus.ready && accept) begin
                instr_q <= rd_word;
            end
            if (bus.load) begin
                case (state)
                    LOADING: begin
                        if (!full) begin
                            wp <= wp + WORD_BYTES;
                        end
                        if (bus.load_last) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                        wp    <= WORD_BYTES;
                        state <= bus.load_last ? RUN : LOADING;
                    end
                endcase
            end
        end
    end

    assign bus.load_full   = full;
    assign bus.load_count  = wp;
    assign bus.mem_state   = state;
    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Drives one shared load/fetch stream into three memory variants (LE 1 KiB, BE 1 KiB, LE 16 B)
// and compares every cycle of their outputs with a byte-array reference model.
module tb_instr_mem_loader;
    localparam int R = 48;        // per-variant record: instr, valid, fault, state, count, full
    localparam int W = 3 * R;
    localparam int AB [3] = '{10, 10, 4};
    localparam int BE [3] = '{0, 1, 0};

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    logic [W-1:0] exp_q[$];
    logic [7:0]   m_mem [3][1024];
    int           m_wp [3];
    int           m_st [3];
    logic [31:0]  m_instr [3];

    instr_mem_loader_if #(.ADDR_BITS(10)) if0 ();
    instr_mem_loader_if #(.ADDR_BITS(10)) if1 ();
    instr_mem_loader_if #(.ADDR_BITS(4))  if2 ();

    instr_mem_loader #(.ADDR_BITS(10), .BIG_ENDIAN(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    instr_mem_loader #(.ADDR_BITS(10), .BIG_ENDIAN(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    instr_mem_loader #(.ADDR_BITS(4),  .BIG_ENDIAN(0)) dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model
    task automatic write_word(input int i, input int base, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            m_mem[i][base + k] = (BE[i] != 0) ? w[31 - 8*k -: 8] : w[8*k +: 8];
        end
    endtask

    function automatic logic [31:0] read_word(input int i, input int base);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            if (BE[i] != 0) w = (w << 8) | 32'(m_mem[i][base + k]);
            else            w = w | (32'(m_mem[i][base + k]) << (8 * k));
        end
        return w;
    endfunction

    task automatic model_step(input bit rn, input bit ld, input bit lst, input bit rdy,
                              input logic [31:0] w, input logic [31:0] a);
        logic [W-1:0] rec;
        int           cap;
        bit           v;
        bit           f;
        longint       ea;
        rec = '0;
        for (int i = 0; i < 3; i++) begin
            cap = 1 << AB[i];
            v   = 1'b0;
            f   = 1'b0;
            ea  = longint'({32'd0, a});
            if (!rn) begin
                m_st[i]    = 0;
                m_wp[i]    = 0;
                m_instr[i] = '0;
            end else begin
                if (rdy) begin
                    if (m_st[i] == 2 && !ld && a[1:0] == 2'b00 && ea < cap && ea + 4 <= m_wp[i]) begin
                        v          = 1'b1;
                        m_instr[i] = read_word(i, int'(ea));
                    end else begin
                        f = 1'b1;
                    end
                end
                if (ld) begin
                    if (m_st[i] != 1) begin
                        write_word(i, 0, w);
                        m_wp[i] = 4;
                        m_st[i] = lst ? 2 : 1;
                    end else begin
                        if (m_wp[i] < cap) begin
                            write_word(i, m_wp[i], w);
                            m_wp[i] = m_wp[i] + 4;
                        end
                        if (lst) m_st[i] = 2;
                    end
                end
            end
            rec[R*i +: R] = {m_instr[i], v, f, 2'(m_st[i]), 11'(m_wp[i]), (m_wp[i] == cap)};
        end
        exp_q.push_back(rec);
    endtask

    // driver
    task automatic drive(input bit rn, input bit ld, input bit lst, input bit rdy,
                         input logic [31:0] w, input logic [31:0] a);
        @(negedge clk);
        reset_n       = rn;
        if0.load      = ld;  if1.load      = ld;  if2.load      = ld;
        if0.load_last = lst; if1.load_last = lst; if2.load_last = lst;
        if0.store     = w;   if1.store     = w;   if2.store     = w;
        if0.ready     = rdy; if1.ready     = rdy; if2.ready     = rdy;
        if0.address   = a;   if1.address   = a;   if2.address   = a;
        model_step(rn, ld, lst, rdy, w, a);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] a);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, a);
    endtask

    task automatic beat(input logic [31:0] w, input bit lst);
        drive(1'b1, 1'b1, lst, 1'b0, w, 32'h0);
    endtask

    task automatic do_reset(input int n);
        for (int c = 0; c < n; c++) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        logic [W-1:0] rec;
        logic [R-1:0] act [3];
        logic [R-1:0] e;
        #1;
        if (exp_q.size() != 0) begin
            rec    = exp_q.pop_front();
            act[0] = {if0.instruction, if0.instr_valid, if0.fault, if0.mem_state, 11'(if0.load_count), if0.load_full};
            act[1] = {if1.instruction, if1.instr_valid, if1.fault, if1.mem_state, 11'(if1.load_count), if1.load_full};
            act[2] = {if2.instruction, if2.instr_valid, if2.fault, if2.mem_state, 11'(if2.load_count), if2.load_full};
            for (int i = 0; i < 3; i++) begin
                e = rec[R*i +: R];
                total++;
                if (act[i] !== e) begin
                    bad++;
                    $display("FAIL dut%0d_out t=%0t got instr=%h v=%b f=%b st=%0d cnt=%0d full=%b exp instr=%h v=%b f=%b st=%0d cnt=%0d full=%b",
                             i, $time, act[i][47:16], act[i][15], act[i][14], act[i][13:12], act[i][11:1], act[i][0],
                             e[47:16], e[15], e[14], e[13:12], e[11:1], e[0]);
                end
            end
        end
    end

    initial begin
        total         = 0;
        bad           = 0;
        reset_n       = 1'b0;
        if0.load = 1'b0; if1.load = 1'b0; if2.load = 1'b0;
        if0.load_last = 1'b0; if1.load_last = 1'b0; if2.load_last = 1'b0;
        if0.store = '0; if1.store = '0; if2.store = '0;
        if0.ready = 1'b0; if1.ready = 1'b0; if2.ready = 1'b0;
        if0.address = '0; if1.address = '0; if2.address = '0;
        for (int i = 0; i < 3; i++) begin
            m_wp[i] = 0; m_st[i] = 0; m_instr[i] = '0;
        end

        // reset, fetch while EMPTY, three-beat program
        do_reset(2);
        fetch(32'h0);
        beat(32'h11223344, 1'b0);
        beat(32'h55667788, 1'b0);
        beat(32'h99AABBCC, 1'b1);
        fetch(32'h0); fetch(32'h4); fetch(32'h8);
        // misaligned, past program end, past capacity; instruction must hold
        fetch(32'h2); fetch(32'hC); fetch(32'h400); fetch(32'h8000_0000);
        idle(1);
        // load and fetch in the same RUN cycle
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0);
        fetch(32'h0);
        idle(1);

        // overflow of the 16-byte variant
        do_reset(1);
        beat(32'hA0A0A0A0, 1'b0); beat(32'hA1A1A1A1, 1'b0);
        beat(32'hA2A2A2A2, 1'b0); beat(32'hA3A3A3A3, 1'b0);
        beat(32'hA4A4A4A4, 1'b1);
        fetch(32'hC); fetch(32'h10); fetch(32'h0);

        // reset in the middle of a load
        beat(32'hC0FFEE00, 1'b0); beat(32'hC0FFEE04, 1'b0);
        do_reset(1);
        idle(1);
        fetch(32'h0);

        // single last beat, then byte-order peek on the big-endian variant
        beat(32'h11223344, 1'b1);
        @(posedge clk); #2;
        total++;
        if (dut1.mem[0] !== 8'h11) begin
            bad++;
            $display("FAIL be_byte0 got=%h exp=11", dut1.mem[0]);
        end
        fetch(32'h0);
        fetch(32'h4);

        // fill the 1 KiB variants to capacity, with two dropped beats at the end
        for (int n = 0; n < 258; n++) beat($urandom(), n == 257);
        fetch(32'h3FC); fetch(32'h400); fetch(32'h0); fetch(32'hC);
        for (int n = 0; n < 200; n++) fetch(32'(4 * $urandom_range(0, 260)));

        // random mix
        for (int n = 0; n < 2000; n++) begin
            bit          rn;
            bit          ld;
            bit          lst;
            bit          rdy;
            logic [31:0] a;
            rn  = ($urandom_range(0, 99) != 0);
            ld  = ($urandom_range(0, 3) == 0);
            lst = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 48));
                1:       a = 32'(4 * $urandom_range(0, 15));
                2:       a = $urandom();
                default: a = 32'(4 * $urandom_range(0, 260));
            endcase
            drive(rn, ld, lst, rdy, $urandom(), a);
        end

        idle(2);
        @(posedge clk); #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
